// File: rtl/main_mem_ctrl.sv
// Word-wide RAM-backed main-memory controller with a fixed access
// latency, serving single-word reads and writes from the cache unit.
module main_mem_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_cs_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        mem_ack_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t state;
   state_t next;
   logic [3:0] cnt;
   logic [3:0] cnt_next;

   logic                  we_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [31:0]           data_q;

   logic accept;
   logic ack_next;
   logic ram_wr;
   logic ram_rd;

   logic [31:0] ram [DEPTH];

   // Byte-offset and aliasing bits take no part in addressing.
   logic unused_addr;
   assign unused_addr = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         mem_ack_o  <= 1'b0;
         mem_data_o <= '0;
      end else begin
         state     <= next;
         cnt       <= cnt_next;
         mem_ack_o <= ack_next;
         if (ram_rd)
            mem_data_o <= ram[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q   <= mem_we_i;
         idx_q  <= mem_addr_i[ADDR_WIDTH+1:2];
         data_q <= mem_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_wr)
         ram[idx_q] <= data_q;
   end

   always_comb begin
      next     = state;
      cnt_next = cnt;
      unique case (state)
         S_IDLE: begin
            if (mem_cs_i) begin
               next     = S_WAIT;
               cnt_next = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (!mem_cs_i)
               next = S_IDLE;
            else if (cnt == '0)
               next = S_ACK;
            else
               cnt_next = cnt - 4'd1;
         end
         S_ACK:   next = S_IDLE;
         default: next = S_IDLE;
      endcase
   end

   // RAM is touched only on the edge that enters S_ACK; reset drops it.
   always_comb begin
      accept   = (state == S_IDLE) && mem_cs_i;
      ack_next = (state == S_WAIT) && (next == S_ACK);
      ram_wr   = ack_next && we_q && !rst;
      ram_rd   = ack_next && !we_q;
   end

endmodule
